// File: rtl/xm23_pipe_pkg.sv
// xm23_pipe_pkg
// Shared types and constants for the XM23 back-end pipeline controller:
// FSM state encoding, stall reason bit positions, forward-select codes,
// the scoreboard entry layout and a register one-hot helper.
// Optional feature macro used by the files importing this package: PIPE_FWD_EN.

package xm23_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SLEEP = 2'd3
  } pipe_state_e;

  localparam int STALL_RAW_S = 0;
  localparam int STALL_RAW_D = 1;
  localparam int STALL_LOAD  = 2;
  localparam int STALL_SLEEP = 3;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXEC    = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [7:0] mask;
    logic       load;
  } sb_entry_t;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    reg_onehot = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
// Three-entry in-flight write scoreboard (execute, memory, writeback) that
// mirrors the pipeline registers, plus hazard/forward decode for one source
// register port. The top instantiates one copy per source port (S and D);
// both copies receive identical push data so their contents always agree.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   push_en        load push_entry into the execute slot, otherwise a bubble
//   push_entry     entry describing the instruction leaving decode
//   rd_en          this port really reads a register this cycle
//   rd_idx         register index read by this port
//   raw_stall      port must stall on a RAW hazard
//   load_stall     port must stall because the producer is a load
//   any_valid      at least one entry is occupied
//   fwd_sel        forward select (only with PIPE_FWD_EN)

module pipe_scoreboard
  import xm23_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_en,
  input  sb_entry_t  push_entry,
  input  logic       rd_en,
  input  logic [2:0] rd_idx,
  output logic       raw_stall,
  output logic       load_stall,
  output logic       any_valid
`ifdef PIPE_FWD_EN
  ,
  output logic [1:0] fwd_sel
`endif
);

  sb_entry_t  sb [3];
  logic [2:0] match;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb[0] <= '0;
      sb[1] <= '0;
      sb[2] <= '0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= push_en ? push_entry : '0;
    end
  end

  // A writeback-slot write commits at the end of the cycle, so sb[2] still
  // matches like the younger slots.
  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++) begin
      match[i] = rd_en && sb[i].valid && sb[i].mask[rd_idx];
    end
  end

  assign any_valid = sb[0].valid | sb[1].valid | sb[2].valid;

`ifdef PIPE_FWD_EN
  // Only a load still in execute cannot be forwarded: its data arrives from
  // memory one cycle later.
  assign raw_stall  = 1'b0;
  assign load_stall = match[0] & sb[0].load;

  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (match[0]) begin
      fwd_sel = FWD_EXEC;
    end else if (match[1]) begin
      fwd_sel = FWD_MEM;
    end else if (match[2]) begin
      fwd_sel = FWD_WB;
    end
  end
`else
  assign raw_stall  = |match;
  assign load_stall = |(match & {sb[2].load, sb[1].load, sb[0].load});
`endif

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller
// Hazard and flow controller for the XM23 3-stage back-end. Tracks in-flight
// register writes, raises stall reasons, sequences branch-mispredict flushes
// and the SLP drain/sleep hold.
//
// Build option: define PIPE_FWD_EN to enable operand forwarding and the
// fwd_s_o / fwd_d_o ports; without it every RAW hazard stalls.
//
// Parameters:
//   CLEAR_CYCLES   cycles clear_o is held after a mispredict (1..7)
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   dec_valid                decode holds a real instruction
//   dec_rd_s, dec_s          S operand read enable / index
//   dec_rd_d, dec_d          D operand read enable / index
//   dec_wr_d, dec_wr_s       instruction writes D / S
//   dec_load                 result comes from memory access
//   dec_slp                  instruction is SLP
//   branch_fail              branch prediction failed this cycle
//   wake                     wake event, leaves SLEEP
//   stall_o                  stall reasons {0000, sleep, load, raw_d, raw_s}
//   clear_o                  flush the decode->execute register
//   fetch_hold_o             freeze PC/fetch
//   state_o                  current FSM state
//   fwd_s_o, fwd_d_o         forward selects (PIPE_FWD_EN only)
//
// state  | meaning
// RUN    | normal issue, hazards checked against the scoreboard
// FLUSH  | clear_o held while the down-counter runs out
// DRAIN  | SLP accepted, issue blocked until the scoreboard empties
// SLEEP  | issue blocked and fetch frozen until wake

module pipeline_controller
  import xm23_pipe_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic       dec_rd_s,
  input  logic [2:0] dec_s,
  input  logic       dec_rd_d,
  input  logic [2:0] dec_d,
  input  logic       dec_wr_d,
  input  logic       dec_wr_s,
  input  logic       dec_load,
  input  logic       dec_slp,
  input  logic       branch_fail,
  input  logic       wake,
  output logic [7:0] stall_o,
  output logic       clear_o,
  output logic       fetch_hold_o,
  output logic [1:0] state_o
`ifdef PIPE_FWD_EN
  ,
  output logic [1:0] fwd_s_o,
  output logic [1:0] fwd_d_o
`endif
);

  localparam logic [2:0] CLR_RELOAD = 3'(CLEAR_CYCLES - 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  sb_entry_t   push_entry;
  logic        push_en;
  logic        slp_accept;
  logic        raw_s, raw_d, ld_s, ld_d;
  logic        any_s, any_d;
  logic        sb_empty;
  logic        in_flush;
  logic        sleep_stall;

  always_comb begin
    push_entry       = '0;
    push_entry.valid = 1'b1;
    push_entry.load  = dec_load;
    if (dec_wr_d) push_entry.mask = push_entry.mask | reg_onehot(dec_d);
    if (dec_wr_s) push_entry.mask = push_entry.mask | reg_onehot(dec_s);
  end

  pipe_scoreboard u_sb_s (
    .clk        (clk),
    .reset      (reset),
    .push_en    (push_en),
    .push_entry (push_entry),
    .rd_en      (dec_valid & dec_rd_s),
    .rd_idx     (dec_s),
    .raw_stall  (raw_s),
    .load_stall (ld_s),
    .any_valid  (any_s)
`ifdef PIPE_FWD_EN
    ,
    .fwd_sel    (fwd_s_o)
`endif
  );

  pipe_scoreboard u_sb_d (
    .clk        (clk),
    .reset      (reset),
    .push_en    (push_en),
    .push_entry (push_entry),
    .rd_en      (dec_valid & dec_rd_d),
    .rd_idx     (dec_d),
    .raw_stall  (raw_d),
    .load_stall (ld_d),
    .any_valid  (any_d)
`ifdef PIPE_FWD_EN
    ,
    .fwd_sel    (fwd_d_o)
`endif
  );

  // Both copies hold the same entries; combining keeps either copy honest.
  assign sb_empty    = ~(any_s | any_d);

  assign in_flush    = (state_q == ST_FLUSH);
  assign sleep_stall = (state_q == ST_DRAIN) || (state_q == ST_SLEEP);

  always_comb begin
    stall_o                = '0;
    stall_o[STALL_RAW_S]   = raw_s & ~in_flush;
    stall_o[STALL_RAW_D]   = raw_d & ~in_flush;
    stall_o[STALL_LOAD]    = (ld_s | ld_d) & ~in_flush;
    stall_o[STALL_SLEEP]   = sleep_stall;
  end

  assign clear_o      = in_flush;
  assign fetch_hold_o = (state_q == ST_SLEEP);
  assign state_o      = state_q;

  assign push_en    = dec_valid && (stall_o == 8'h00) && !clear_o;
  assign slp_accept = push_en && dec_slp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // branch_fail outranks everything, including an ongoing flush (reload).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_fail) begin
      state_d = ST_FLUSH;
      cnt_d   = CLR_RELOAD;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (slp_accept) state_d = ST_DRAIN;
        end
        ST_FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_DRAIN: begin
          if (sb_empty) state_d = ST_SLEEP;
        end
        ST_SLEEP: begin
          if (wake) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

endmodule
